fetch_pair_queue: RTL and testbench

//  Instruction-supply end of the dual-issue p0/p1 IR interface: fetches 16-bit words from
//  the shared memory, buffers them in program order and presents the oldest two to

---
 rtl/kl_isa_pkg.sv | 14 +
 rtl/fetch_pair_queue_if.sv | 34 +++
 rtl/fetch_ring.sv | 64 ++++++
 rtl/fetch_pair_queue.sv | 103 ++++++++++
 tb/tb_fetch_pair_queue.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/kl_isa_pkg.sv
// ISA-level constants and types shared by the instruction fetch path.
package kl_isa_pkg;

    localparam int          IR_W     = 16;
    localparam logic [2:0]  OPC_HALT = 3'b111;

    typedef logic [IR_W-1:0] ir_t;
    typedef logic [1:0]      issue_cnt_t;

    function automatic logic is_halt(input ir_t ir);
        return ir[IR_W-1 -: 3] == OPC_HALT;
    endfunction

endpackage

// File: rtl/fetch_pair_queue_if.sv
// Fetch/issue bundle between the CPU control side (master) and the instruction queue (slave).
interface fetch_pair_queue_if
    import kl_isa_pkg::*;
#(
    parameter int ADDR_W = 9
);

    // Handshake: imem_rdata is valid exactly one cycle after imem_rd was high; p0/p1 words are
    // consumed at a rising edge by issue_cnt, which must never exceed the number of valid slots.
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_grant;
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    ir_t               imem_rdata;
    ir_t               p0_IR_out;
    ir_t               p1_IR_out;
    logic              p0_valid;
    logic              p1_valid;
    logic [ADDR_W-1:0] p0_pc;
    logic [ADDR_W-1:0] p1_pc;
    issue_cnt_t        issue_cnt;

    modport master (
        output redirect, redirect_pc, mem_grant, imem_rdata, issue_cnt,
        input  imem_rd, imem_addr, p0_IR_out, p1_IR_out, p0_valid, p1_valid, p0_pc, p1_pc
    );

    modport slave (
        input  redirect, redirect_pc, mem_grant, imem_rdata, issue_cnt,
        output imem_rd, imem_addr, p0_IR_out, p1_IR_out, p0_valid, p1_valid, p0_pc, p1_pc
    );

endinterface

// File: rtl/fetch_ring.sv
// Circular instruction buffer: one write port at tail, two read ports at head and head+1.
module fetch_ring #(
    parameter int DEPTH = 8,
    parameter int W     = 25
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [1:0]               pop_cnt_i,
    output logic [W-1:0]             rd0_o,
    output logic [W-1:0]             rd1_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, head_nx;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (push_i) begin
                tail_d = tail_q + PTR_W'(1);
            end
            head_d  = head_q + PTR_W'(pop_cnt_i);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_cnt_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; the top masks unoccupied slots with the valid flags.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

    assign head_nx = head_q + PTR_W'(1);
    assign rd0_o   = mem_q[head_q];
    assign rd1_o   = mem_q[head_nx];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_pair_queue.sv
// Instruction supply for the dual-issue p0/p1 decode pair: fetch, buffer in order, present oldest two.
module fetch_pair_queue
    import kl_isa_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_pair_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0] dbg_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = IR_W + ADDR_W;
    localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] tag_pc_q, tag_pc_d;
    logic              inflight_q, inflight_d;
    logic              halted_q, halted_d;

    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occupancy;
    logic [ENT_W-1:0]  rd0, rd1;
    logic              push, halt_in, room, fetch;
    issue_cnt_t        pop;

    always_comb begin
        push      = inflight_q & ~bus.redirect;
        halt_in   = inflight_q & is_halt(bus.imem_rdata);
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
        room      = occupancy < DEPTH_C;
        // An arriving HALT also blocks the fetch in its own cycle so nothing past it is requested.
        fetch     = ~reset & bus.mem_grant & ~halted_q & ~halt_in & ~bus.redirect & room;

        pop = bus.issue_cnt;
        if (bus.redirect) begin
            pop = '0;
        end else if ({{(CNT_W-2){1'b0}}, bus.issue_cnt} > count) begin
            pop = count[1:0];
        end

        fetch_pc_d = fetch_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (fetch) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end

        inflight_d = fetch;
        tag_pc_d   = fetch ? fetch_pc_q : tag_pc_q;
        halted_d   = bus.redirect ? 1'b0 : (halted_q | (push & halt_in));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= '0;
            tag_pc_q   <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            tag_pc_q   <= tag_pc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

    fetch_ring #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_ring (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (bus.redirect),
        .push_i    (push),
        .wdata_i   ({bus.imem_rdata, tag_pc_q}),
        .pop_cnt_i (pop),
        .rd0_o     (rd0),
        .rd1_o     (rd1),
        .count_o   (count)
    );

    // Empty slots read as all-zero words, which decode as a harmless MOV R0.
    always_comb begin
        bus.imem_rd   = fetch;
        bus.imem_addr = fetch_pc_q;
        bus.p0_valid  = count != '0;
        bus.p1_valid  = count >= CNT_W'(2);
        bus.p0_IR_out = bus.p0_valid ? rd0[ENT_W-1 -: IR_W] : '0;
        bus.p1_IR_out = bus.p1_valid ? rd1[ENT_W-1 -: IR_W] : '0;
        bus.p0_pc     = bus.p0_valid ? rd0[ADDR_W-1:0] : '0;
        bus.p1_pc     = bus.p1_valid ? rd1[ADDR_W-1:0] : '0;
    end

    assign dbg_count_o = count;

    a_issue_le_count: assert property (@(posedge clk) disable iff (reset || bus.redirect)
        {{(CNT_W-2){1'b0}}, bus.issue_cnt} <= count);

endmodule

// File: tb/tb_fetch_pair_queue.sv
// Directed bench for fetch_pair_queue with a one-cycle-latency instruction memory.
module tb_fetch_pair_queue;

    logic       clk;
    logic       reset;
    logic [3:0] dbg_count;
    int         checks;
    int         errors;

    logic [15:0] imem [512];

    fetch_pair_queue_if #(.ADDR_W(9)) bif();

    fetch_pair_queue #(
        .DEPTH  (8),
        .ADDR_W (9)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bif),
        .dbg_count_o (dbg_count)
    );

    // ---------------- clock / memory model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bif.imem_rd) bif.imem_rdata <= imem[bif.imem_addr];
    end

    function automatic logic [15:0] exp_word(input logic [8:0] pc);
        if (pc == 9'd0) return 16'hD102;
        if (pc == 9'd1) return 16'hD003;
        return 16'h2000 | {7'b0, pc};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        bif.redirect = 1'b0;
        bif.redirect_pc = '0;
        bif.mem_grant = 1'b1;
        bif.issue_cnt = 2'd0;
        bif.imem_rdata = '0;
        tick(); tick();
        #1;
        checks++; if (bif.p0_valid !== 1'b0) begin errors++; $display("FAIL reset_p0_valid: got %0b want 0", bif.p0_valid); end
        checks++; if (bif.p1_valid !== 1'b0) begin errors++; $display("FAIL reset_p1_valid: got %0b want 0", bif.p1_valid); end
        checks++; if (bif.p0_IR_out !== 16'h0) begin errors++; $display("FAIL reset_p0_ir: got %h want 0000", bif.p0_IR_out); end
        checks++; if (bif.p1_IR_out !== 16'h0) begin errors++; $display("FAIL reset_p1_ir: got %h want 0000", bif.p1_IR_out); end
        checks++; if (bif.imem_rd !== 1'b0) begin errors++; $display("FAIL reset_imem_rd: got %0b want 0", bif.imem_rd); end
        checks++; if (bif.imem_addr !== 9'h0) begin errors++; $display("FAIL reset_addr: got %h want 000", bif.imem_addr); end
        checks++; if (dbg_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dbg_count); end
    endtask

    task automatic test_startup;
        reset = 1'b0;
        #1;
        checks++; if (bif.imem_rd !== 1'b1 || bif.imem_addr !== 9'h0) begin errors++; $display("FAIL start_fetch0: got rd=%0b addr=%h want rd=1 addr=000", bif.imem_rd, bif.imem_addr); end
        tick(); #1;
        checks++; if (bif.p0_valid !== 1'b0 || bif.imem_addr !== 9'h1) begin errors++; $display("FAIL start_c1: got v0=%0b addr=%h want v0=0 addr=001", bif.p0_valid, bif.imem_addr); end
        tick(); #1;
        checks++; if (bif.p0_valid !== 1'b1 || bif.p0_IR_out !== 16'hD102 || bif.p0_pc !== 9'h0) begin errors++; $display("FAIL start_p0: got v=%0b ir=%h pc=%h want v=1 ir=D102 pc=000", bif.p0_valid, bif.p0_IR_out, bif.p0_pc); end
        checks++; if (bif.p1_valid !== 1'b0 || bif.p1_IR_out !== 16'h0) begin errors++; $display("FAIL start_p1_empty: got v=%0b ir=%h want v=0 ir=0000", bif.p1_valid, bif.p1_IR_out); end
        tick(); #1;
        checks++; if (bif.p1_valid !== 1'b1 || bif.p1_IR_out !== 16'hD003 || bif.p1_pc !== 9'h1) begin errors++; $display("FAIL start_p1: got v=%0b ir=%h pc=%h want v=1 ir=D003 pc=001", bif.p1_valid, bif.p1_IR_out, bif.p1_pc); end
        tick();
    endtask

    task automatic test_full;
        bif.issue_cnt = 2'd0;
        repeat (10) tick();
        #1;
        checks++; if (dbg_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", dbg_count); end
        checks++; if (bif.imem_rd !== 1'b0 || bif.imem_addr !== 9'h8) begin errors++; $display("FAIL full_stall: got rd=%0b addr=%h want rd=0 addr=008", bif.imem_rd, bif.imem_addr); end
        checks++; if (bif.p0_IR_out !== 16'hD102 || bif.p1_IR_out !== 16'hD003 || bif.p0_pc !== 9'h0) begin errors++; $display("FAIL full_no_overwrite: got p0=%h p1=%h pc=%h want D102 D003 000", bif.p0_IR_out, bif.p1_IR_out, bif.p0_pc); end
        bif.issue_cnt = 2'd2;
        #1;
        checks++; if (bif.imem_rd !== 1'b0) begin errors++; $display("FAIL full_issue_ignored: got rd=%0b want 0", bif.imem_rd); end
        tick();
        bif.issue_cnt = 2'd0;
        #1;
        checks++; if (bif.imem_rd !== 1'b1 || bif.imem_addr !== 9'h8) begin errors++; $display("FAIL full_resume: got rd=%0b addr=%h want rd=1 addr=008", bif.imem_rd, bif.imem_addr); end
        checks++; if (dbg_count !== 4'd6 || bif.p0_pc !== 9'h2) begin errors++; $display("FAIL full_after_pop: got cnt=%0d pc=%h want cnt=6 pc=002", dbg_count, bif.p0_pc); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp_pc;
        int         issue_v;
        bif.issue_cnt = 2'd1;
        #1;
        checks++; if (bif.p0_pc !== 9'h2 || bif.p1_pc !== 9'h3) begin errors++; $display("FAIL issue1_before: got p0=%h p1=%h want 002 003", bif.p0_pc, bif.p1_pc); end
        tick();
        bif.issue_cnt = 2'd0;
        #1;
        checks++; if (bif.p0_pc !== 9'h3 || bif.p0_IR_out !== exp_word(9'h3)) begin errors++; $display("FAIL issue1_shift: got pc=%h ir=%h want pc=003 ir=%h", bif.p0_pc, bif.p0_IR_out, exp_word(9'h3)); end
        exp_pc = 9'h3;
        for (int i = 0; i < 20; i++) begin
            issue_v = bif.p1_valid ? 2 : (bif.p0_valid ? 1 : 0);
            bif.issue_cnt = issue_v[1:0];
            #1;
            checks++; if (bif.p0_valid !== 1'b1) begin errors++; $display("FAIL b2b_p0_valid[%0d]: got %0b want 1", i, bif.p0_valid); end
            if (bif.p0_valid) begin
                checks++; if (bif.p0_pc !== exp_pc || bif.p0_IR_out !== exp_word(exp_pc)) begin errors++; $display("FAIL b2b_p0[%0d]: got pc=%h ir=%h want pc=%h ir=%h", i, bif.p0_pc, bif.p0_IR_out, exp_pc, exp_word(exp_pc)); end
            end
            if (bif.p1_valid) begin
                checks++; if (bif.p1_pc !== exp_pc + 9'd1 || bif.p1_IR_out !== exp_word(exp_pc + 9'd1)) begin errors++; $display("FAIL b2b_p1[%0d]: got pc=%h ir=%h want pc=%h", i, bif.p1_pc, bif.p1_IR_out, exp_pc + 9'd1); end
            end
            exp_pc = exp_pc + 9'(issue_v);
            tick();
        end
        bif.issue_cnt = 2'd0;
    endtask

    task automatic test_redirect;
        bif.issue_cnt = 2'd0;
        bif.redirect = 1'b1;
        bif.redirect_pc = 9'h040;
        #1;
        checks++; if (bif.imem_rd !== 1'b0) begin errors++; $display("FAIL redir_no_fetch: got rd=%0b want 0", bif.imem_rd); end
        tick();
        bif.redirect = 1'b0;
        #1;
        checks++; if (bif.p0_valid !== 1'b0 || dbg_count !== 4'd0) begin errors++; $display("FAIL redir_flush: got v=%0b cnt=%0d want v=0 cnt=0", bif.p0_valid, dbg_count); end
        checks++; if (bif.imem_rd !== 1'b1 || bif.imem_addr !== 9'h040) begin errors++; $display("FAIL redir_fetch: got rd=%0b addr=%h want rd=1 addr=040", bif.imem_rd, bif.imem_addr); end
        tick(); #1;
        checks++; if (bif.p0_valid !== 1'b0) begin errors++; $display("FAIL redir_stale_dropped: got v=%0b pc=%h want v=0", bif.p0_valid, bif.p0_pc); end
        tick(); #1;
        checks++; if (bif.p0_valid !== 1'b1 || bif.p0_pc !== 9'h040 || bif.p0_IR_out !== exp_word(9'h040)) begin errors++; $display("FAIL redir_target: got v=%0b pc=%h ir=%h want v=1 pc=040 ir=%h", bif.p0_valid, bif.p0_pc, bif.p0_IR_out, exp_word(9'h040)); end
        tick();
    endtask

    task automatic test_halt;
        imem[5] = 16'hE000;
        bif.issue_cnt = 2'd0;
        bif.redirect = 1'b1;
        bif.redirect_pc = 9'h0;
        tick();
        bif.redirect = 1'b0;
        repeat (12) tick();
        #1;
        checks++; if (dbg_count !== 4'd6 || bif.imem_rd !== 1'b0 || bif.imem_addr !== 9'h6) begin errors++; $display("FAIL halt_stop: got cnt=%0d rd=%0b addr=%h want cnt=6 rd=0 addr=006", dbg_count, bif.imem_rd, bif.imem_addr); end
        bif.issue_cnt = 2'd2;
        #1;
        checks++; if (bif.p0_pc !== 9'h0 || bif.p1_pc !== 9'h1) begin errors++; $display("FAIL halt_drain0: got p0=%h p1=%h want 000 001", bif.p0_pc, bif.p1_pc); end
        tick(); #1;
        checks++; if (bif.p0_pc !== 9'h2 || bif.p0_IR_out !== exp_word(9'h2)) begin errors++; $display("FAIL halt_drain1: got pc=%h ir=%h want pc=002", bif.p0_pc, bif.p0_IR_out); end
        tick(); #1;
        checks++; if (bif.p0_pc !== 9'h4 || bif.p1_pc !== 9'h5 || bif.p1_IR_out !== 16'hE000) begin errors++; $display("FAIL halt_drain2: got p0=%h p1=%h ir1=%h want 004 005 E000", bif.p0_pc, bif.p1_pc, bif.p1_IR_out); end
        tick();
        bif.issue_cnt = 2'd0;
        #1;
        checks++; if (bif.p0_valid !== 1'b0 || bif.p0_IR_out !== 16'h0 || bif.imem_rd !== 1'b0) begin errors++; $display("FAIL halt_empty: got v=%0b ir=%h rd=%0b want v=0 ir=0000 rd=0", bif.p0_valid, bif.p0_IR_out, bif.imem_rd); end
        tick(); tick(); #1;
        checks++; if (bif.imem_rd !== 1'b0) begin errors++; $display("FAIL halt_hold: got rd=%0b want 0", bif.imem_rd); end
        imem[5] = exp_word(9'h5);
        bif.redirect = 1'b1;
        bif.redirect_pc = 9'h010;
        tick();
        bif.redirect = 1'b0;
        #1;
        checks++; if (bif.imem_rd !== 1'b1 || bif.imem_addr !== 9'h010) begin errors++; $display("FAIL halt_release: got rd=%0b addr=%h want rd=1 addr=010", bif.imem_rd, bif.imem_addr); end
        tick();
    endtask

    task automatic test_grant_reset;
        logic [8:0] exp_pc;
        int         issue_v;
        exp_pc = 9'h010;
        for (int i = 0; i < 16; i++) begin
            bif.mem_grant = (i % 2 == 0);
            issue_v = bif.p0_valid ? 1 : 0;
            bif.issue_cnt = issue_v[1:0];
            #1;
            if (!bif.mem_grant) begin
                checks++; if (bif.imem_rd !== 1'b0) begin errors++; $display("FAIL grant_stall[%0d]: got rd=%0b want 0", i, bif.imem_rd); end
            end
            if (bif.p0_valid) begin
                checks++; if (bif.p0_pc !== exp_pc || bif.p0_IR_out !== exp_word(exp_pc)) begin errors++; $display("FAIL grant_order[%0d]: got pc=%h ir=%h want pc=%h", i, bif.p0_pc, bif.p0_IR_out, exp_pc); end
            end
            exp_pc = exp_pc + 9'(issue_v);
            tick();
        end
        checks++; if (exp_pc < 9'h014) begin errors++; $display("FAIL grant_progress: got next pc=%h want >=014", exp_pc); end
        bif.mem_grant = 1'b1;
        bif.issue_cnt = 2'd0;
        reset = 1'b1;
        tick(); #1;
        checks++; if (bif.p0_valid !== 1'b0 || bif.p1_valid !== 1'b0 || dbg_count !== 4'd0) begin errors++; $display("FAIL rst_mid_valid: got v0=%0b v1=%0b cnt=%0d want 0 0 0", bif.p0_valid, bif.p1_valid, dbg_count); end
        checks++; if (bif.p0_IR_out !== 16'h0 || bif.p1_IR_out !== 16'h0 || bif.p0_pc !== 9'h0) begin errors++; $display("FAIL rst_mid_ir: got p0=%h p1=%h pc=%h want 0000 0000 000", bif.p0_IR_out, bif.p1_IR_out, bif.p0_pc); end
        checks++; if (bif.imem_rd !== 1'b0 || bif.imem_addr !== 9'h0) begin errors++; $display("FAIL rst_mid_fetch: got rd=%0b addr=%h want rd=0 addr=000", bif.imem_rd, bif.imem_addr); end
        reset = 1'b0;
        tick(); #1;
        checks++; if (bif.p0_valid !== 1'b0) begin errors++; $display("FAIL rst_restart_early: got v=%0b want 0", bif.p0_valid); end
        tick(); #1;
        checks++; if (bif.p0_valid !== 1'b1 || bif.p0_pc !== 9'h0 || bif.p0_IR_out !== 16'hD102) begin errors++; $display("FAIL rst_restart: got v=%0b pc=%h ir=%h want v=1 pc=000 ir=D102", bif.p0_valid, bif.p0_pc, bif.p0_IR_out); end
        tick();
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks = 0;
        errors = 0;
        for (int a = 0; a < 512; a++) imem[a] = exp_word(9'(a));
        test_reset();
        test_startup();
        test_full();
        test_back_to_back();
        test_redirect();
        test_halt();
        test_grant_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
